rsa_modexp_seq: RTL and testbench
=================================

Name: rsa_modexp_seq

Overview:
- Sequential, parametrised modular exponentiation engine: result = base^exp mod n.
- Successor to the fixed-width combinational encryptor/decryptor pair. One instance serves either direction: exp=e to encrypt, exp=d to decrypt.
- Uses right-to-left square-and-multiply. Each modular product is formed by an interleaved shift-add reducer, so there is no wide multiplier and no divider.
- Sits between the key/letter registers and the link logic; start/done handshake.

Parameters:
- WIDTH, 26, width of n, base and result.
- EXP_W, 26, width of exp.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- n  in  WIDTH  modulus.
- base  in  WIDTH  message/ciphertext; any value, including base >= n.
- exp  in  EXP_W  exponent.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse; result valid in that cycle and held afterwards.
- result  out  WIDTH  base^exp mod n.
- err  out  1  set with done when n==0.

Behaviour:
- Reset (async, any state):
  - state=IDLE; busy=0, done=0, err=0, result=0.
  - All internal registers cleared.
  - An operation in flight is abandoned; no done is produced.
- States: IDLE, RED, MUL, SQR, DONE.
- IDLE, start=1 at edge T0:
  - Capture n, base, exp into internal registers. Later input changes have no effect.
  - If n==0: go to DONE at T0+1 with err=1, result=0.
  - Otherwise: acc_res = (n==1) ? 0 : 1; go to RED.
- Modmul primitive, a*b mod n, with b < n, exactly WIDTH cycles:
  - Scan a from MSB to LSB.
  - Each cycle: t = 2*acc; if t >= n then t = t - n. If the a bit is 1: t = t + b; if t >= n then t = t - n. Then acc = t.
  - Internal datapath is WIDTH+1 bits; acc < n is an invariant.
- RED (WIDTH cycles): modmul(base, 1) gives base mod n into the working base register.
- Per exponent bit i = 0..EXP_W-1, LSB first:
  - MUL (WIDTH cycles), only if exp[i]=1: acc_res = modmul(acc_res, base).
  - SQR (WIDTH cycles): base = modmul(base, base).
  - After SQR: if the remaining exponent bits above i are all zero, or i == EXP_W-1, go to DONE. Otherwise move to the next bit.
  - exp==0: after RED go directly to DONE.
- DONE (1 cycle): done=1, busy=0, result=acc_res; return to IDLE.
- result holds until the next DONE or reset.
- start asserted in any state other than IDLE is ignored.
- start in the same cycle as done is ignored. It is accepted on the next IDLE cycle if still high.
- Latency: done is asserted at cycle T0+1+WIDTH*(1+K+P).
  - K = number of 1 bits in exp.
  - P = index of the highest set bit of exp, plus 1 (P=0 when exp==0).
  - For n==0, done is at T0+1.

Optional Feature:
- Macro: MODEXP_CONST_TIME_EN.
- Defined:
  - MUL runs for every bit. When exp[i]=0 the product is computed and discarded; acc_res is unchanged.
  - All EXP_W bits are processed; there is no early exit.
  - Fixed latency WIDTH*(1+2*EXP_W) cycles, independent of exp and base, for timing-attack resistance.
  - The n==0 path is unchanged.
- Undefined: data-dependent latency as given above.

Test Plan:
- Defaults, n=35, exp=5, base=2, start at T0 -> result=32, err=0, done exactly at T0+157.
- n=35, exp=5, base=32 -> result=2. Sweep base 0..25 with encrypt then decrypt (e=d=5) -> every decrypted value equals its base.
- n=35, base=40, exp=1 -> result=5 (reduction path). exp=0, base=9 -> result=1. n=1, base=7, exp=3 -> result=0.
- n=0 -> done at T0+1 with err=1, result=0. Then a legal request -> err=0.
- Hold start high across a whole operation; change the inputs mid-run; assert rst mid-RED -> only one operation is accepted, captured values are used, and reset gives busy=0, done=0, result=0 with no done pulse.
- With MODEXP_CONST_TIME_EN: exp=5 and exp=0x3FFFFFF -> both give done at T0+1+1378, with correct results (32, and base^(2^26-1) mod 35 checked against the model).

Source files
------------

// File: rtl/rsa_modexp_seq.sv
// Sequential modexp (base^exp mod n): right-to-left square-and-multiply over a shift-add modmul, start/done handshake.
// Each modmul takes WIDTH cycles. Defining MODEXP_CONST_TIME_EN gives a fixed, exp-independent latency.
module rsa_modexp_seq #(
   parameter int WIDTH = 26,
   parameter int EXP_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] base,
   input  logic [EXP_W-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [BW-1:0]    BIT_LAST = BW'(EXP_W - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

`ifdef MODEXP_CONST_TIME_EN
   localparam bit CONST_TIME = 1'b1;
`else
   localparam bit CONST_TIME = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_RED,
      S_MUL,
      S_SQR,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] a_src;
   logic [WIDTH-1:0] b_op;
   logic             a_bit;
   logic [WIDTH:0]   dbl;
   logic [WIDTH-1:0] dbl_red;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] prod;
   logic             mm_last;
   logic             last_bit;

   // One modmul step. Operands stay stable for the whole product because
   // the destination register is only written on the final step.
   always_comb begin
      a_src   = (state_q == S_MUL) ? res_q : base_q;
      b_op    = (state_q == S_RED) ? ONE : base_q;
      a_bit   = a_src[CNT_LAST - cnt_q];
      dbl     = {acc_q, 1'b0};
      dbl_red = (dbl >= {1'b0, n_q}) ? (dbl[WIDTH-1:0] - n_q) : dbl[WIDTH-1:0];
      sum     = {1'b0, dbl_red} + {1'b0, b_op};
      prod    = dbl_red;
      if (a_bit) begin
         prod = (sum >= {1'b0, n_q}) ? (sum[WIDTH-1:0] - n_q) : sum[WIDTH-1:0];
      end
      mm_last  = (cnt_q == CNT_LAST);
      last_bit = (bit_q == BIT_LAST) || (!CONST_TIME && ((exp_q >> 1) == '0));
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      base_d   = base_q;
      exp_d    = exp_q;
      res_d    = res_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d    = n;
               base_d = base;
               exp_d  = exp;
               acc_d  = '0;
               cnt_d  = '0;
               bit_d  = '0;
               if (n == '0) begin
                  res_d    = '0;
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  res_d   = (n == ONE) ? '0 : ONE;
                  state_d = S_RED;
               end
            end
         end

         S_RED, S_MUL, S_SQR: begin
            acc_d = prod;
            cnt_d = cnt_q + CW'(1);
            if (mm_last) begin
               acc_d = '0;
               cnt_d = '0;
               case (state_q)
                  S_RED: begin
                     base_d = prod;
                     if (!CONST_TIME && exp_q == '0) begin
                        result_d = res_q;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                     end else begin
                        state_d = (CONST_TIME || exp_q[0]) ? S_MUL : S_SQR;
                     end
                  end
                  S_MUL: begin
                     // In constant-time mode a zero bit still runs the product; it is dropped here.
                     if (exp_q[0]) begin
                        res_d = prod;
                     end
                     state_d = S_SQR;
                  end
                  default: begin
                     base_d = prod;
                     exp_d  = exp_q >> 1;
                     bit_d  = bit_q + BW'(1);
                     if (last_bit) begin
                        result_d = res_q;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                     end else begin
                        state_d = (CONST_TIME || exp_d[0]) ? S_MUL : S_SQR;
                     end
                  end
               endcase
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         base_q   <= '0;
         exp_q    <= '0;
         res_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         res_q    <= res_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == S_RED) || (state_q == S_MUL) || (state_q == S_SQR);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Scoreboard bench for rsa_modexp_seq: directed vectors push expected result/err/done-cycle, a monitor compares on done.
module tb_rsa_modexp_seq;

   typedef struct {
      logic [25:0] res;
      logic        err;
      int          done_cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start_s;
   logic [25:0] n_s;
   logic [25:0] base_s;
   logic [25:0] exp_s;
   logic        busy;
   logic        done;
   logic [25:0] result;
   logic        err;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   rsa_modexp_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .n     (n_s),
      .base  (base_s),
      .exp   (exp_s),
      .busy  (busy),
      .done  (done),
      .result(result),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   function automatic logic [25:0] mexp(input logic [25:0] nn, input logic [25:0] bb, input logic [25:0] ee);
      longint unsigned m, r, x;
      if (nn == 0) return 26'd0;
      m = 64'(nn);
      r = 64'd1 % m;
      x = 64'(bb) % m;
      for (int i = 0; i < 26; i++) begin
         if (ee[i]) r = (r * x) % m;
         x = (x * x) % m;
      end
      return r[25:0];
   endfunction

   function automatic int lat_of(input logic [25:0] nn, input logic [25:0] ee);
      int k = 0;
      int p = 0;
      for (int i = 0; i < 26; i++) begin
         if (ee[i]) begin
            k++;
            p = i + 1;
         end
      end
      if (nn == 0) return 1;
`ifdef MODEXP_CONST_TIME_EN
      return 1 + 26 * (1 + 2 * 26);
`else
      return 1 + 26 * (1 + k + p);
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done result=%0d cyc=%0d want=no_done", result, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("result", 64'(result), 64'(mon_e.res));
            check("err", 64'(err), 64'(mon_e.err));
            check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            check("busy_in_done", 64'(busy), 64'd0);
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((busy || done) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("idle_reached", 64'(busy | done), 64'd0);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("op_completes", 64'(done), 64'd1);
   endtask

   task automatic do_op(input logic [25:0] nn, input logic [25:0] bb, input logic [25:0] ee,
                        input logic [25:0] want);
      exp_t e;
      wait_idle();
      n_s     = nn;
      base_s  = bb;
      exp_s   = ee;
      start_s = 1'b1;
      e.res      = want;
      e.err      = (nn == 0);
      e.done_cyc = cyc + lat_of(nn, ee);
      sb.push_back(e);
      @(negedge clk);
      start_s = 1'b0;
      if (nn != 0) check("busy_after_start", 64'(busy), 64'd1);
      wait_done();
   endtask

   initial begin
      exp_t        e;
      logic [25:0] ct;
      int          sweep_step;

      rst     = 1'b1;
      start_s = 1'b0;
      n_s     = '0;
      base_s  = '0;
      exp_s   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst = 1'b0;

      do_op(26'd35, 26'd2, 26'd5, 26'd32);
      do_op(26'd35, 26'd32, 26'd5, 26'd2);
      do_op(26'd35, 26'd40, 26'd1, 26'd5);
      do_op(26'd35, 26'd9, 26'd0, 26'd1);
      do_op(26'd1, 26'd7, 26'd3, 26'd0);
      do_op(26'd0, 26'd5, 26'd5, 26'd0);
      do_op(26'd35, 26'd3, 26'd5, 26'd33);

      // 2 has order 12 mod 35 and (2^26-1) mod 12 = 3, so 2^(2^26-1) mod 35 = 8.
      check("model_allones", 64'(mexp(26'd35, 26'd2, 26'h3FFFFFF)), 64'd8);
      do_op(26'd35, 26'd2, 26'h3FFFFFF, 26'd8);
      do_op(26'd35, 26'd3, 26'h3FFFFFF, mexp(26'd35, 26'd3, 26'h3FFFFFF));

`ifdef MODEXP_CONST_TIME_EN
      sweep_step = 5;
`else
      sweep_step = 1;
`endif
      for (int b = 0; b < 26; b += sweep_step) begin
         ct = mexp(26'd35, 26'(b), 26'd5);
         do_op(26'd35, 26'(b), 26'd5, ct);
         do_op(26'd35, ct, 26'd5, 26'(b));
      end

      // start held high through a whole operation, inputs changed mid-run
      wait_idle();
      n_s     = 26'd35;
      base_s  = 26'd2;
      exp_s   = 26'd5;
      start_s = 1'b1;
      e.res      = 26'd32;
      e.err      = 1'b0;
      e.done_cyc = cyc + lat_of(26'd35, 26'd5);
      sb.push_back(e);
      @(negedge clk);
      check("hold_busy", 64'(busy), 64'd1);
      n_s    = 26'd33;
      base_s = 26'd7;
      exp_s  = 26'd3;
      wait_done();
      e.res      = 26'd13;
      e.err      = 1'b0;
      e.done_cyc = cyc + 1 + lat_of(26'd33, 26'd3);
      sb.push_back(e);
      @(negedge clk);
      check("idle_gap_busy", 64'(busy), 64'd0);
      check("idle_gap_done", 64'(done), 64'd0);
      @(negedge clk);
      check("second_accept", 64'(busy), 64'd1);
      start_s = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      check("no_third_op", 64'(busy), 64'd0);

      // reset in the middle of RED abandons the operation
      wait_idle();
      n_s     = 26'd35;
      base_s  = 26'd2;
      exp_s   = 26'd5;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_red_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_result", 64'(result), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("post_rst_idle", 64'(busy), 64'd0);

      do_op(26'd35, 26'd2, 26'd5, 26'd32);
      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
